// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: sequences MEM-stage loads/stores onto a word-wide req/ack
// memory bus with no byte enables. Sub-word stores become read-modify-write.
// Optional feature macro: MEM_CTRL_TIMEOUT_EN (bus ack timeout with err_o pulse).
//
// state  | meaning
// IDLE   | ready for a new request
// RD     | load: bus read outstanding
// RMW_RD | byte/half store: reading the target word
// RMW_WR | byte/half store: writing the merged word (first cycle is the req gap)
// WR     | word store: bus write outstanding
// RESP   | one-cycle completion, pipeline released

module mem_access_ctrl #(
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_we_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [DATA_W-1:0] req_wdata_i,
    input  logic [2:0]        req_type_i,
    output logic              resp_valid_o,
    output logic [DATA_W-1:0] resp_rdata_o,
    output logic              stall_o,
    output logic              bus_req_o,
    output logic              bus_we_o,
    output logic [ADDR_W-1:0] bus_addr_o,
    output logic [DATA_W-1:0] bus_wdata_o,
    input  logic              bus_ack_i,
    input  logic [DATA_W-1:0] bus_rdata_i,
    output logic              err_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_RMW_RD,
        S_RMW_WR,
        S_WR,
        S_RESP
    } state_t;

    state_t            state_q;
    state_t            state_d;

    // type[1:0]: 00 byte, 01 half, 1x word; type[2] only selects extension downstream
    logic [1:0]        size_q;
    logic [1:0]        addr_lo_q;
    logic [15:0]       wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic              bus_req_q;
    logic              bus_we_q;
    logic [ADDR_W-1:0] bus_addr_q;
    logic [DATA_W-1:0] bus_wdata_q;

    logic              xfer;
    logic              timeout_hit;
    logic              req_word;
    logic [4:0]        shamt;
    logic [DATA_W-1:0] load_word;
    logic [DATA_W-1:0] merged;

    logic              unused_type;
    assign unused_type = req_type_i[2];

    assign xfer     = bus_req_q & bus_ack_i;
    assign req_word = req_type_i[1];

    // Load data is returned lane-aligned; word loads ignore the low address bits
    assign shamt     = size_q[1] ? 5'd0 : {addr_lo_q, 3'b000};
    assign load_word = bus_rdata_i >> shamt;

    // Merge the stored lane into the word read back from memory
    always_comb begin
        merged = bus_rdata_i;
        if (size_q == 2'b00) begin
            merged[{addr_lo_q, 3'b000} +: 8] = wdata_q[7:0];
        end else begin
            merged[{addr_lo_q[1], 4'b0000} +: 16] = wdata_q[15:0];
        end
    end

`ifdef MEM_CTRL_TIMEOUT_EN
    localparam int unsigned TO_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ?
                                   $clog2(TIMEOUT_CYCLES + 1) : 8;

    logic [TO_W-1:0] to_cnt_q;
    logic            wait_cyc;
    logic            err_q;

    assign wait_cyc    = bus_req_q & ~bus_ack_i;
    assign timeout_hit = wait_cyc && (to_cnt_q == TO_W'(1));
    assign err_o       = err_q;

    // Down-counter of unacked request cycles; reloaded whenever no request is out
    always_ff @(posedge clk) begin
        if (rst) begin
            to_cnt_q <= TO_W'(TIMEOUT_CYCLES);
            err_q    <= 1'b0;
        end else begin
            err_q <= timeout_hit;
            if (!bus_req_q) begin
                to_cnt_q <= TO_W'(TIMEOUT_CYCLES);
            end else if (wait_cyc) begin
                to_cnt_q <= to_cnt_q - TO_W'(1);
            end
        end
    end
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
    assign timeout_hit    = 1'b0;
    assign err_o          = 1'b0;
`endif

    // Next-state decode
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid_i) begin
                    if (!req_we_i) begin
                        state_d = S_RD;
                    end else if (req_word) begin
                        state_d = S_WR;
                    end else begin
                        state_d = S_RMW_RD;
                    end
                end
            end
            S_RD, S_WR, S_RMW_WR: begin
                if (timeout_hit || xfer) begin
                    state_d = S_RESP;
                end
            end
            S_RMW_RD: begin
                if (timeout_hit) begin
                    state_d = S_RESP;
                end else if (xfer) begin
                    state_d = S_RMW_WR;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State register, request latches and registered bus outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            size_q      <= 2'b00;
            addr_lo_q   <= 2'b00;
            wdata_q     <= '0;
            rdata_q     <= '0;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                S_IDLE: begin
                    if (req_valid_i) begin
                        size_q      <= req_type_i[1:0];
                        addr_lo_q   <= req_addr_i[1:0];
                        wdata_q     <= req_wdata_i[15:0];
                        rdata_q     <= '0;
                        bus_req_q   <= 1'b1;
                        bus_we_q    <= req_we_i & req_word;
                        bus_addr_q  <= {req_addr_i[ADDR_W-1:2], 2'b00};
                        bus_wdata_q <= req_wdata_i;
                    end
                end
                S_RD: begin
                    if (xfer) begin
                        bus_req_q <= 1'b0;
                        rdata_q   <= load_word;
                    end else if (timeout_hit) begin
                        bus_req_q <= 1'b0;
                    end
                end
                S_RMW_RD: begin
                    if (xfer) begin
                        bus_req_q   <= 1'b0;
                        bus_we_q    <= 1'b1;
                        bus_wdata_q <= merged;
                    end else if (timeout_hit) begin
                        bus_req_q <= 1'b0;
                    end
                end
                S_RMW_WR: begin
                    if (!bus_req_q) begin
                        bus_req_q <= 1'b1;
                    end else if (xfer || timeout_hit) begin
                        bus_req_q <= 1'b0;
                    end
                end
                S_WR: begin
                    if (xfer || timeout_hit) begin
                        bus_req_q <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign req_ready_o  = (state_q == S_IDLE);
    assign resp_valid_o = (state_q == S_RESP);
    assign resp_rdata_o = (state_q == S_RESP) ? rdata_q : '0;
    assign stall_o      = ((state_q == S_IDLE) & req_valid_i) |
                          ((state_q != S_IDLE) & (state_q != S_RESP));
    assign bus_req_o    = bus_req_q;
    assign bus_we_o     = bus_we_q;
    assign bus_addr_o   = bus_addr_q;
    assign bus_wdata_o  = bus_wdata_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: directed accesses, a bus responder that checks
// every transfer, and a response monitor fed from an expected-response queue.
module tb_mem_access_ctrl;

    localparam logic [2:0] T_B  = 3'b000;
    localparam logic [2:0] T_H  = 3'b001;
    localparam logic [2:0] T_W  = 3'b010;
    localparam logic [2:0] T_BU = 3'b100;
    localparam logic [2:0] T_HU = 3'b101;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } resp_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
    } bus_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic        req_we_i = 1'b0;
    logic [31:0] req_addr_i = '0;
    logic [31:0] req_wdata_i = '0;
    logic [2:0]  req_type_i = '0;
    logic        resp_valid_o;
    logic [31:0] resp_rdata_o;
    logic        stall_o;
    logic        bus_req_o;
    logic        bus_we_o;
    logic [31:0] bus_addr_o;
    logic [31:0] bus_wdata_o;
    logic        bus_ack_i = 1'b0;
    logic [31:0] bus_rdata_i = '0;
    logic        err_o;

    int          n_vec = 0;
    int          n_err = 0;
    bit          ack_en = 1'b1;
    int          ack_delay = 0;
    int          wait_cnt = 0;
    int          wr_cnt = 0;
    logic [31:0] bus_rd_word = '0;
    resp_t       resp_exp_q[$];
    bus_t        bus_exp_q[$];
    resp_t       mon_r;
    bus_t        mon_b;

    always #5 clk = ~clk;

    mem_access_ctrl #(
        .ADDR_W         (32),
        .DATA_W         (32),
        .TIMEOUT_CYCLES (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .req_we_i     (req_we_i),
        .req_addr_i   (req_addr_i),
        .req_wdata_i  (req_wdata_i),
        .req_type_i   (req_type_i),
        .resp_valid_o (resp_valid_o),
        .resp_rdata_o (resp_rdata_o),
        .stall_o      (stall_o),
        .bus_req_o    (bus_req_o),
        .bus_we_o     (bus_we_o),
        .bus_addr_o   (bus_addr_o),
        .bus_wdata_o  (bus_wdata_o),
        .bus_ack_i    (bus_ack_i),
        .bus_rdata_i  (bus_rdata_i),
        .err_o        (err_o)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Bus responder: acks after ack_delay waiting cycles and checks each transfer
    always @(negedge clk) begin
        bus_ack_i = 1'b0;
        if (bus_req_o && bus_we_o) wr_cnt++;
        if (bus_req_o && ack_en && !rst) begin
            if (wait_cnt >= ack_delay) begin
                bus_ack_i   = 1'b1;
                bus_rdata_i = bus_we_o ? 32'h0 : bus_rd_word;
                wait_cnt    = 0;
                if (bus_exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL bus_unexpected: got we=%0b addr=%h data=%h required no transfer",
                             bus_we_o, bus_addr_o, bus_wdata_o);
                end else begin
                    mon_b = bus_exp_q.pop_front();
                    check("bus_we", {31'b0, bus_we_o}, {31'b0, mon_b.we});
                    check("bus_addr", bus_addr_o, mon_b.addr);
                    if (mon_b.we) check("bus_wdata", bus_wdata_o, mon_b.data);
                end
            end else begin
                wait_cnt++;
            end
        end else begin
            wait_cnt = 0;
        end
    end

    // Response monitor: every resp_valid_o pulse consumes one expected response
    always @(negedge clk) begin
        if (resp_valid_o) begin
            if (resp_exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL resp_unexpected: got rdata=%h err=%0b required no response",
                         resp_rdata_o, err_o);
            end else begin
                mon_r = resp_exp_q.pop_front();
                check("resp_rdata", resp_rdata_o, mon_r.rdata);
                check("resp_err", {31'b0, err_o}, {31'b0, mon_r.err});
            end
        end
    end

    task automatic exp_bus(input logic we, input logic [31:0] addr, input logic [31:0] data);
        bus_t b;
        b.we = we; b.addr = addr; b.data = data;
        bus_exp_q.push_back(b);
    endtask

    task automatic idle(input int n);
        req_valid_i = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    // Drives one request (starting at a negedge) and holds it until RESP is seen.
    // exp_trace is bus_req_o per cycle, oldest in the MSB, RESP cycle last.
    task automatic do_access(input string name, input logic we, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [2:0] typ,
                             input logic [31:0] rd_word, input int delay,
                             input logic [31:0] exp_rdata, input logic exp_err,
                             input int exp_cyc, input logic [31:0] exp_trace);
        int          cyc;
        logic [31:0] trace;
        bit          done;
        bit          stall_bad;
        resp_t       r;
        bus_rd_word = rd_word;
        ack_delay   = delay;
        r.rdata = exp_rdata;
        r.err   = exp_err;
        resp_exp_q.push_back(r);
        req_valid_i = 1'b1;
        req_we_i    = we;
        req_addr_i  = addr;
        req_wdata_i = wdata;
        req_type_i  = typ;
        cyc = 0; trace = '0; done = 1'b0; stall_bad = 1'b0;
        while (!done && cyc < 400) begin
            @(negedge clk);
            cyc++;
            trace = {trace[30:0], bus_req_o};
            if (resp_valid_o) begin
                done = 1'b1;
                check({name, " stall_in_resp"}, {31'b0, stall_o}, 32'd0);
            end else if (!stall_o) begin
                stall_bad = 1'b1;
            end
        end
        check({name, " latency"}, cyc, exp_cyc);
        check({name, " req_trace"}, trace, exp_trace);
        check({name, " stall_held"}, {31'b0, stall_bad}, 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish required finish");
        $fatal(1);
    end

    initial begin
        int  wr_before;
        bit  bad;

        repeat (2) @(negedge clk);
        check("rst req_ready", {31'b0, req_ready_o}, 32'd1);
        check("rst stall", {31'b0, stall_o}, 32'd0);
        check("rst resp_valid", {31'b0, resp_valid_o}, 32'd0);
        check("rst resp_rdata", resp_rdata_o, 32'd0);
        check("rst bus_req_we_err", {29'b0, bus_req_o, bus_we_o, err_o}, 32'd0);
        check("rst bus_addr", bus_addr_o, 32'd0);
        check("rst bus_wdata", bus_wdata_o, 32'd0);
        rst = 1'b0;
        idle(1);

        exp_bus(1'b0, 32'h1000, 32'h0);
        do_access("ld_b_1003", 1'b0, 32'h1003, 32'h0, T_B, 32'hAABBCCDD, 2,
                  32'h000000AA, 1'b0, 4, 32'b1110);
        idle(1);
        exp_bus(1'b0, 32'h2000, 32'h0);
        exp_bus(1'b1, 32'h2000, 32'h11225A44);
        do_access("sb_2001", 1'b1, 32'h2001, 32'h0000005A, T_B, 32'h11223344, 0,
                  32'h0, 1'b0, 4, 32'b1010);
        idle(1);
        exp_bus(1'b0, 32'h3000, 32'h0);
        exp_bus(1'b1, 32'h3000, 32'hBEEF0304);
        do_access("sh_3002", 1'b1, 32'h3002, 32'h0000BEEF, T_H, 32'h01020304, 1,
                  32'h0, 1'b0, 6, 32'b110110);
        idle(1);
        exp_bus(1'b1, 32'h3004, 32'hCAFEF00D);
        do_access("sw_3005", 1'b1, 32'h3005, 32'hCAFEF00D, T_W, 32'h0, 0,
                  32'h0, 1'b0, 2, 32'b10);
        idle(1);
        exp_bus(1'b0, 32'h3000, 32'h0);
        exp_bus(1'b1, 32'h3000, 32'h5678C0D0);
        do_access("sh_3003", 1'b1, 32'h3003, 32'h12345678, T_H, 32'hA0B0C0D0, 0,
                  32'h0, 1'b0, 4, 32'b1010);
        idle(1);
        exp_bus(1'b0, 32'h2000, 32'h0);
        exp_bus(1'b1, 32'h2000, 32'h11223377);
        do_access("sb_2000", 1'b1, 32'h2000, 32'hFFFFFF77, T_B, 32'h11223344, 0,
                  32'h0, 1'b0, 4, 32'b1010);
        idle(1);
        exp_bus(1'b0, 32'h2000, 32'h0);
        exp_bus(1'b1, 32'h2000, 32'h99223344);
        do_access("sb_2003", 1'b1, 32'h2003, 32'h00000099, T_B, 32'h11223344, 0,
                  32'h0, 1'b0, 4, 32'b1010);
        idle(1);
        exp_bus(1'b0, 32'h4000, 32'h0);
        do_access("lhu_4002", 1'b0, 32'h4002, 32'h0, T_HU, 32'h87654321, 0,
                  32'h00008765, 1'b0, 2, 32'b10);
        idle(1);
        exp_bus(1'b0, 32'h4000, 32'h0);
        do_access("lbu_4001", 1'b0, 32'h4001, 32'h0, T_BU, 32'h87654321, 1,
                  32'h00876543, 1'b0, 3, 32'b110);
        idle(1);
        exp_bus(1'b0, 32'h4004, 32'h0);
        do_access("lw_4006", 1'b0, 32'h4006, 32'h0, T_W, 32'hDEADBEEF, 0,
                  32'hDEADBEEF, 1'b0, 2, 32'b10);

        // Back-to-back with req_valid held: second request accepted after RESP
        idle(1);
        exp_bus(1'b0, 32'h1000, 32'h0);
        do_access("b2b_ld", 1'b0, 32'h1002, 32'h0, T_B, 32'hAABBCCDD, 0,
                  32'h0000AABB, 1'b0, 2, 32'b10);
        exp_bus(1'b1, 32'h5000, 32'h0BADF00D);
        do_access("b2b_sw", 1'b1, 32'h5000, 32'h0BADF00D, T_W, 32'h0, 0,
                  32'h0, 1'b0, 3, 32'b010);

        // Reset during RMW_RD: the merged write must never appear
        idle(1);
        ack_en      = 1'b0;
        req_valid_i = 1'b1;
        req_we_i    = 1'b1;
        req_addr_i  = 32'h2001;
        req_wdata_i = 32'h5A;
        req_type_i  = T_B;
        @(negedge clk);
        check("rmw_rd bus_req", {31'b0, bus_req_o}, 32'd1);
        check("rmw_rd bus_we", {31'b0, bus_we_o}, 32'd0);
        wr_before   = wr_cnt;
        rst         = 1'b1;
        req_valid_i = 1'b0;
        @(negedge clk);
        check("rst_mid bus_req", {31'b0, bus_req_o}, 32'd0);
        check("rst_mid req_ready", {31'b0, req_ready_o}, 32'd1);
        rst    = 1'b0;
        ack_en = 1'b1;
        repeat (6) @(negedge clk);
        check("rst_mid no_write", wr_cnt - wr_before, 32'd0);
        check("rst_mid still_idle", {31'b0, req_ready_o}, 32'd1);

        // No ack at all
        idle(1);
        ack_en = 1'b0;
`ifdef MEM_CTRL_TIMEOUT_EN
        do_access("timeout", 1'b0, 32'h6000, 32'h0, T_W, 32'h12345678, 0,
                  32'h0, 1'b1, 5, 32'b11110);
        ack_en = 1'b1;
`else
        req_valid_i = 1'b1;
        req_we_i    = 1'b0;
        req_addr_i  = 32'h6000;
        req_type_i  = T_W;
        bad = 1'b0;
        repeat (300) begin
            @(negedge clk);
            if (!stall_o || !bus_req_o || err_o || resp_valid_o) bad = 1'b1;
        end
        check("no_ack stall_held", {31'b0, bad}, 32'd0);
        rst         = 1'b1;
        req_valid_i = 1'b0;
        @(negedge clk);
        rst    = 1'b0;
        ack_en = 1'b1;
        check("no_ack recover", {31'b0, req_ready_o}, 32'd1);
`endif

        idle(4);
        check("resp queue drained", resp_exp_q.size(), 32'd0);
        check("bus queue drained", bus_exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
